// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM states and store lane-merge helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_ERR    = 3'd4
  } lsu_state_e;

  // Replaces the addressed byte/half lane of old_word; any other funct3 is a full-word store.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [2:0]  funct3,
                                             input logic [1:0]  addr_lo);
    logic [31:0] merged;
    merged = old_word;
    if (funct3 == F3_B) begin
      case (addr_lo)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (funct3 == F3_H) begin
      if (addr_lo[1]) merged[31:16] = wdata[15:0];
      else            merged[15:0]  = wdata[15:0];
    end else begin
      merged = wdata;
    end
    return merged;
  endfunction

  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    if (we) bad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    else    bad = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    return bad;
  endfunction

  function automatic logic access_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) bad = 1'b1;
    if (funct3 == F3_W && addr_lo != 2'b00)                bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response bus and data-memory bus interfaces for the load/store unit

interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  modport master (
    output mem_A, mem_WE, mem_WD,
    input  mem_RD
  );

  modport slave (
    input  mem_A, mem_WE, mem_WD,
    output mem_RD
  );
endinterface

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - selects the byte/half lane of a memory word and sign/zero-extends it
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  // Halfword lane ignores addr[0]: misaligned halves read the aligned-down lane.
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      F3_W:    o_data = i_word;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with read-modify-write sub-word stores
// Optional misalignment trapping: define LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_IDX_W = 10
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req_bus,
  lsu_mem_if.master mem_bus
);

  lsu_state_e  r_state;
  logic        r_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_A;
  logic        r_mem_WE;
  logic [31:0] r_mem_WD;

  logic        w_req_err;
  logic [31:0] w_word_idx;
  logic [31:0] w_load_data;

  assign w_word_idx = {{(32 - MEM_IDX_W){1'b0}}, req_bus.req_addr[MEM_IDX_W+1:2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_req_err = funct3_illegal(req_bus.req_we, req_bus.req_funct3)
                   | access_misaligned(req_bus.req_funct3, req_bus.req_addr[1:0]);
`else
  assign w_req_err = funct3_illegal(req_bus.req_we, req_bus.req_funct3);
`endif

  lsu_load_extend u_load_extend (
    .i_word    (mem_bus.mem_RD),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_wdata     <= 32'h0;
      r_mem_A     <= 32'h0;
      r_mem_WE    <= 1'b0;
      r_mem_WD    <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_bus.req_valid) begin
            r_funct3  <= req_bus.req_funct3;
            r_addr_lo <= req_bus.req_addr[1:0];
            r_wdata   <= req_bus.req_wdata;
            r_ready   <= 1'b0;
            if (w_req_err) begin
              r_state     <= ST_ERR;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_mem_A <= w_word_idx;
              if (!req_bus.req_we) begin
                r_state     <= ST_LOAD;
                r_rsp_valid <= 1'b1;
              end else if (req_bus.req_funct3 == F3_W) begin
                r_state     <= ST_WRITE;
                r_mem_WE    <= 1'b1;
                r_mem_WD    <= req_bus.req_wdata;
                r_rsp_valid <= 1'b1;
              end else begin
                r_state <= ST_RMW_RD;
              end
            end
          end
        end
        // Old word is merged as it is read, so WRITE only has to present it.
        ST_RMW_RD: begin
          r_mem_WD    <= lane_merge(mem_bus.mem_RD, r_wdata, r_funct3, r_addr_lo);
          r_mem_WE    <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_WRITE;
        end
        ST_LOAD, ST_WRITE, ST_ERR: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_mem_WE    <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_mem_WE    <= 1'b0;
        end
      endcase
    end
  end

  assign req_bus.req_ready = r_ready;
  assign req_bus.rsp_valid = r_rsp_valid;
  assign req_bus.rsp_err   = r_rsp_err;
  assign req_bus.rsp_rdata = (r_state == ST_LOAD) ? w_load_data : 32'h0;

  assign mem_bus.mem_A  = r_mem_A;
  assign mem_bus.mem_WE = r_mem_WE;
  assign mem_bus.mem_WD = r_mem_WD;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit with a word-addressed memory
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_count = 0;

  logic [31:0] mem [0:1023];

  lsu_req_if rq();
  lsu_mem_if mb();

  load_store_unit #(.MEM_IDX_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_bus (rq),
    .mem_bus (mb)
  );

  always #5 clk = ~clk;

  assign mb.mem_RD = mem[mb.mem_A[9:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h8899AABB;
    end else if (mb.mem_WE) begin
      mem[mb.mem_A[9:0]] <= mb.mem_WD;
    end
  end

  always @(posedge clk) begin
    if (mb.mem_WE) wr_count <= wr_count + 1;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_writes;
    int          chk_idx;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic err, output int lat);
    int guard;
    rq.req_valid  = 1'b1;
    rq.req_we     = we;
    rq.req_funct3 = f3;
    rq.req_addr   = addr;
    rq.req_wdata  = wdata;
    guard = 0;
    while (!rq.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", guard);
    end
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
    lat = 1;
    while (!rq.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = rq.rsp_rdata;
    err = rq.rsp_err;
    @(posedge clk); #1;
    chk("rsp_pulse_end", {31'h0, rq.rsp_valid}, 32'h0);
    chk("ready_restored", {31'h0, rq.req_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          wr_before;
    logic [31:0] word8;

    vecs[0]  = '{0, F3_B,  32'h16, 32'h0,        32'hFFFFFF99, 0, 1, 0, -1, 32'h0};
    vecs[1]  = '{0, F3_BU, 32'h16, 32'h0,        32'h00000099, 0, 1, 0, -1, 32'h0};
    vecs[2]  = '{0, F3_H,  32'h14, 32'h0,        32'hFFFFAABB, 0, 1, 0, -1, 32'h0};
    vecs[3]  = '{0, F3_HU, 32'h16, 32'h0,        32'h00008899, 0, 1, 0, -1, 32'h0};
    vecs[4]  = '{0, F3_W,  32'h14, 32'h0,        32'h8899AABB, 0, 1, 0, -1, 32'h0};
    vecs[5]  = '{1, F3_B,  32'h15, 32'h11,       32'h0,        0, 2, 1,  5, 32'h889911BB};
    vecs[6]  = '{0, F3_W,  32'h14, 32'h0,        32'h889911BB, 0, 1, 0, -1, 32'h0};
    vecs[7]  = '{1, F3_W,  32'h20, 32'hDEADBEEF, 32'h0,        0, 1, 1,  8, 32'hDEADBEEF};
    vecs[8]  = '{0, F3_H,  32'h22, 32'h0,        32'hFFFFDEAD, 0, 1, 0, -1, 32'h0};
    vecs[9]  = '{0, F3_HU, 32'h20, 32'h0,        32'h0000BEEF, 0, 1, 0, -1, 32'h0};
    vecs[10] = '{0, F3_B,  32'h23, 32'h0,        32'hFFFFFFDE, 0, 1, 0, -1, 32'h0};
    vecs[11] = '{0, F3_BU, 32'h21, 32'h0,        32'h000000BE, 0, 1, 0, -1, 32'h0};
    vecs[12] = '{1, F3_H,  32'h22, 32'hABCD1234, 32'h0,        0, 2, 1,  8, 32'h1234BEEF};
    vecs[13] = '{0, F3_W,  32'h20, 32'h0,        32'h1234BEEF, 0, 1, 0, -1, 32'h0};
    vecs[14] = '{0, 3'b011, 32'h20, 32'h0,       32'h0,        1, 1, 0,  8, 32'h1234BEEF};
    vecs[15] = '{1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0,       1, 1, 0,  8, 32'h1234BEEF};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[16] = '{0, F3_W,  32'h22, 32'h0,        32'h0,        1, 1, 0,  8, 32'h1234BEEF};
    vecs[17] = '{1, F3_W,  32'h25, 32'hCAFEF00D, 32'h0,        1, 1, 0,  9, 32'h0};
    vecs[18] = '{0, F3_H,  32'h15, 32'h0,        32'h0,        1, 1, 0, -1, 32'h0};
`else
    vecs[16] = '{0, F3_W,  32'h22, 32'h0,        32'h1234BEEF, 0, 1, 0, -1, 32'h0};
    vecs[17] = '{1, F3_W,  32'h25, 32'hCAFEF00D, 32'h0,        0, 1, 1,  9, 32'hCAFEF00D};
    vecs[18] = '{0, F3_H,  32'h15, 32'h0,        32'h000011BB, 0, 1, 0, -1, 32'h0};
`endif
    vecs[19] = '{1, F3_B,  32'h17, 32'hFFFFFF7F, 32'h0,        0, 2, 1,  5, 32'h7F9911BB};
    vecs[20] = '{0, F3_B,  32'h17, 32'h0,        32'h0000007F, 0, 1, 0, -1, 32'h0};
    vecs[21] = '{0, F3_H,  32'h16, 32'h0,        32'h00007F99, 0, 1, 0, -1, 32'h0};
    vecs[22] = '{0, F3_B,  32'h14, 32'h0,        32'hFFFFFFBB, 0, 1, 0, -1, 32'h0};

    rq.req_valid  = 1'b0;
    rq.req_we     = 1'b0;
    rq.req_funct3 = 3'b000;
    rq.req_addr   = 32'h0;
    rq.req_wdata  = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_init = 1'b0;

    chk("reset_req_ready", {31'h0, rq.req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rq.rsp_valid}, 32'h0);
    chk("reset_rsp_err",   {31'h0, rq.rsp_err},   32'h0);
    chk("reset_rsp_rdata", rq.rsp_rdata,          32'h0);
    chk("reset_mem_A",     mb.mem_A,              32'h0);
    chk("reset_mem_WE",    {31'h0, mb.mem_WE},    32'h0);
    chk("reset_mem_WD",    mb.mem_WD,             32'h0);

    for (int i = 0; i < NV; i++) begin
      wr_before = wr_count;
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_write_cycles", i), wr_count - wr_before, vecs[i].exp_writes);
      if (vecs[i].chk_idx >= 0)
        chk($sformatf("v%0d_mem_word", i), mem[vecs[i].chk_idx], vecs[i].exp_word);
    end

    // Reset during the RMW read of a halfword store must abort with no write.
    word8     = mem[8];
    wr_before = wr_count;
    rq.req_valid  = 1'b1;
    rq.req_we     = 1'b1;
    rq.req_funct3 = F3_H;
    rq.req_addr   = 32'h20;
    rq.req_wdata  = 32'h00005555;
    chk("rmw_rst_ready_before", {31'h0, rq.req_ready}, 32'h1);
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
    chk("rmw_rst_in_rmw_ready", {31'h0, rq.req_ready}, 32'h0);
    chk("rmw_rst_in_rmw_we",    {31'h0, mb.mem_WE},    32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmw_rst_ready",     {31'h0, rq.req_ready}, 32'h1);
    chk("rmw_rst_rsp_valid", {31'h0, rq.rsp_valid}, 32'h0);
    chk("rmw_rst_mem_WE",    {31'h0, mb.mem_WE},    32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rmw_rst_no_write", wr_count - wr_before, 32'h0);
    chk("rmw_rst_mem8",     mem[8], word8);

    run_req(1'b0, F3_W, 32'h20, 32'h0, rd, err, lat);
    chk("post_rst_lw_rdata", rd, 32'h1234BEEF);
    chk("post_rst_lw_err", {31'h0, err}, 32'h0);
    chk("post_rst_lw_latency", lat, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
